sequence_accumulator: RTL and testbench

SEQUENCE_ACCUMULATOR -- requirements
Module: sequence_accumulator

---
 rtl/sequence_accumulator.sv | 111 +++++++++++
 tb/tb_sequence_accumulator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_accumulator.sv
// Drains WORD_COUNT words from an upstream memory, one registered read strobe per word,
// accumulating their sum, maximum, minimum and count.
module sequence_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  correct_read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  request_read,
  output logic                  busy,
  output logic [4:0]            count,
  output logic [DATA_WIDTH+3:0] sum,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [DATA_WIDTH-1:0] min_val,
  output logic                  result_valid
);

  localparam logic [4:0] WordCountL = 5'(WORD_COUNT);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPulse,
    StRelease
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [4:0]            count_q, count_d;
  logic [DATA_WIDTH+3:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWait;
          count_d = '0;
          sum_d   = '0;
          max_d   = '0;
          min_d   = '1;
          valid_d = 1'b0;
        end
      end
      StWait: begin
        // Capture while the upstream pointer still addresses this word; the pulse follows.
        if (correct_read) begin
          sum_d   = sum_q + {4'b0000, data_in};
          count_d = count_q + 5'd1;
          if (data_in > max_q) max_d = data_in;
          if (data_in < min_q) min_d = data_in;
          state_d = StPulse;
        end
      end
      StPulse: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (count_q == WordCountL) begin
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    // Strobe is registered from the next state so it is high exactly while in StPulse.
    req_d = (state_d == StPulse);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
      valid_q <= valid_d;
    end
  end

  assign request_read = req_q;
  assign busy         = (state_q != StIdle);
  assign count        = count_q;
  assign sum          = sum_q;
  assign max_val      = max_q;
  assign min_val      = min_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_sequence_accumulator.sv
// Directed bench for sequence_accumulator with a small upstream memory model
// that advances its read pointer on every request_read pulse.
module tb_sequence_accumulator;

  logic        clk = 1'b0;
  logic        reset, start, correct_read, request_read, busy, result_valid;
  logic [7:0]  data_in, max_val, min_val;
  logic [4:0]  count;
  logic [11:0] sum;

  logic [7:0] mem [0:31];
  int         rd_ptr = 0;
  int         n_avail = 0;
  logic       up_rst = 1'b0;
  int         pulse_cnt = 0;
  int         low_run = 2;
  int         viol = 0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sequence_accumulator #(.DATA_WIDTH(8), .WORD_COUNT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .correct_read (correct_read),
    .data_in      (data_in),
    .request_read (request_read),
    .busy         (busy),
    .count        (count),
    .sum          (sum),
    .max_val      (max_val),
    .min_val      (min_val),
    .result_valid (result_valid)
  );

  assign data_in      = mem[rd_ptr[4:0]];
  assign correct_read = (rd_ptr < n_avail);

  // Upstream pointer plus pulse monitor: counts pulses, flags back-to-back or tight pulses.
  always @(posedge clk) begin
    if (up_rst) begin
      rd_ptr    <= 0;
      pulse_cnt <= 0;
      low_run   <= 2;
      viol      <= 0;
    end else if (request_read) begin
      rd_ptr    <= rd_ptr + 1;
      pulse_cnt <= pulse_cnt + 1;
      if (low_run < 2) viol <= viol + 1;
      low_run   <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic clear_upstream();
    @(negedge clk) up_rst = 1'b1;
    @(negedge clk) up_rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Edges after the start-sampling edge until result_valid is seen; -1 on timeout.
  task automatic wait_valid(output int cyc);
    int c = 0;
    cyc = -1;
    while (c < 300) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (result_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_pulses(input int n);
    int c = 0;
    while (pulse_cnt < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (pulse_cnt < n) begin
      n_checks++;
      $display("FAIL wait_pulses: got %0d pulses, expected %0d", pulse_cnt, n);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    n_avail = 16;
  endtask

  task automatic test_reset();
    start = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (request_read !== 1'b0) $display("FAIL rst_req: got %b expected 0", request_read);
      else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (sum !== 12'd0) $display("FAIL rst_sum: got %0d expected 0", sum); else n_pass++;
    n_checks++; if (max_val !== 8'h00) $display("FAIL rst_max: got %h expected 00", max_val);
      else n_pass++;
    n_checks++; if (min_val !== 8'hFF) $display("FAIL rst_min: got %h expected ff", min_val);
      else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", result_valid);
      else n_pass++;
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    load_ramp();
    clear_upstream();
    do_start();
    wait_valid(cyc);
    // Start-sampling edge counts as edge 1, so valid appears on edge 49.
    n_checks++; if (cyc !== 48) $display("FAIL basic_latency: got %0d expected 48", cyc); else n_pass++;
    n_checks++; if (sum !== 12'd136) $display("FAIL basic_sum: got %0d expected 136", sum); else n_pass++;
    n_checks++; if (max_val !== 8'd16) $display("FAIL basic_max: got %0d expected 16", max_val);
      else n_pass++;
    n_checks++; if (min_val !== 8'd1) $display("FAIL basic_min: got %0d expected 1", min_val); else n_pass++;
    n_checks++; if (count !== 5'd16) $display("FAIL basic_count: got %0d expected 16", count); else n_pass++;
    n_checks++; if (pulse_cnt !== 16) $display("FAIL basic_pulses: got %0d expected 16", pulse_cnt);
      else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL basic_spacing: got %0d violations expected 0", viol);
      else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (result_valid !== 1'b1 || sum !== 12'd136 || pulse_cnt !== 16)
      $display("FAIL basic_hold: got valid=%b sum=%0d pulses=%0d expected 1/136/16",
               result_valid, sum, pulse_cnt);
      else n_pass++;
  endtask

  task automatic test_all_ff();
    int cyc;
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    n_avail = 16;
    clear_upstream();
    do_start();
    wait_valid(cyc);
    n_checks++; if (sum !== 12'hFF0) $display("FAIL ff_sum: got %h expected ff0", sum); else n_pass++;
    n_checks++; if (max_val !== 8'hFF || min_val !== 8'hFF)
      $display("FAIL ff_maxmin: got %h/%h expected ff/ff", max_val, min_val);
      else n_pass++;
    n_checks++; if (count !== 5'd16 || cyc !== 48)
      $display("FAIL ff_count: got count=%0d cyc=%0d expected 16/48", count, cyc);
      else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    int highs = 0;
    load_ramp();
    n_avail = 5;
    clear_upstream();
    do_start();
    wait_pulses(5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (request_read) highs++;
    end
    n_checks++; if (busy !== 1'b1 || count !== 5'd5)
      $display("FAIL stall_state: got busy=%b count=%0d expected 1/5", busy, count);
      else n_pass++;
    n_checks++; if (highs !== 0 || pulse_cnt !== 5)
      $display("FAIL stall_pulses: got highs=%0d pulses=%0d expected 0/5", highs, pulse_cnt);
      else n_pass++;
    n_avail = 16;
    wait_valid(cyc);
    n_checks++; if (sum !== 12'd136 || max_val !== 8'd16 || min_val !== 8'd1 || count !== 5'd16)
      $display("FAIL stall_result: got sum=%0d max=%0d min=%0d count=%0d expected 136/16/1/16",
               sum, max_val, min_val, count);
      else n_pass++;
    n_checks++; if (pulse_cnt !== 16 || viol !== 0)
      $display("FAIL stall_total: got pulses=%0d viol=%0d expected 16/0", pulse_cnt, viol);
      else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    load_ramp();
    clear_upstream();
    do_start();
    wait_pulses(7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || request_read !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL mid_rst_ctrl: got busy=%b req=%b valid=%b expected 0/0/0",
               busy, request_read, result_valid);
      else n_pass++;
    n_checks++; if (count !== 5'd0 || sum !== 12'd0 || max_val !== 8'h00 || min_val !== 8'hFF)
      $display("FAIL mid_rst_data: got count=%0d sum=%0d max=%h min=%h expected 0/0/00/ff",
               count, sum, max_val, min_val);
      else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (pulse_cnt !== 7 || busy !== 1'b0)
      $display("FAIL mid_rst_quiet: got pulses=%0d busy=%b expected 7/0", pulse_cnt, busy);
      else n_pass++;
    clear_upstream();
    do_start();
    wait_valid(cyc);
    n_checks++; if (cyc !== 48 || sum !== 12'd136 || count !== 5'd16 || pulse_cnt !== 16)
      $display("FAIL mid_rst_rerun: got cyc=%0d sum=%0d count=%0d pulses=%0d expected 48/136/16/16",
               cyc, sum, count, pulse_cnt);
      else n_pass++;
  endtask

  task automatic test_start_during_run();
    int cyc = 0;
    logic seen = 1'b0;
    load_ramp();
    clear_upstream();
    do_start();
    while (cyc < 300 && !seen) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      // The last retrigger is sampled while the FSM sits in RELEASE on the final word.
      start = (cyc == 10 || cyc == 30 || cyc == 47);
      seen = result_valid;
    end
    start = 1'b0;
    n_checks++; if (!seen || cyc !== 48)
      $display("FAIL restart_latency: got cyc=%0d valid=%b expected 48/1", cyc, seen);
      else n_pass++;
    n_checks++; if (pulse_cnt !== 16 || sum !== 12'd136 || max_val !== 8'd16 || min_val !== 8'd1)
      $display("FAIL restart_result: got pulses=%0d sum=%0d max=%0d min=%0d expected 16/136/16/1",
               pulse_cnt, sum, max_val, min_val);
      else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b1)
      $display("FAIL restart_idle: got busy=%b valid=%b expected 0/1", busy, result_valid);
      else n_pass++;
  endtask

  task automatic test_minmax();
    int cyc;
    logic [7:0] words [0:15];
    words = '{8'd9, 8'd3, 8'd200, 8'd3, 8'd200, 8'd9, 8'd50, 8'd3,
              8'd200, 8'd100, 8'd3, 8'd7, 8'd200, 8'd9, 8'd3, 8'd10};
    for (int i = 0; i < 16; i++) mem[i] = words[i];
    n_avail = 16;
    clear_upstream();
    do_start();
    wait_pulses(1);
    n_checks++; if (max_val !== 8'd9 || min_val !== 8'd9 || sum !== 12'd9)
      $display("FAIL mm_first: got max=%0d min=%0d sum=%0d expected 9/9/9", max_val, min_val, sum);
      else n_pass++;
    wait_pulses(4);
    n_checks++; if (max_val !== 8'd200 || min_val !== 8'd3 || count !== 5'd4 || sum !== 12'd215)
      $display("FAIL mm_four: got max=%0d min=%0d count=%0d sum=%0d expected 200/3/4/215",
               max_val, min_val, count, sum);
      else n_pass++;
    wait_valid(cyc);
    n_checks++; if (max_val !== 8'd200 || min_val !== 8'd3 || sum !== 12'd1009)
      $display("FAIL mm_final: got max=%0d min=%0d sum=%0d expected 200/3/1009",
               max_val, min_val, sum);
      else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_all_ff();
    test_stall();
    test_reset_mid_run();
    test_start_during_run();
    test_minmax();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
